// File: rtl/clk_div_pkg.sv
// Shared defaults and types for the programmable multi-channel clock divider.
// Divisor defaults target the 25 MHz board clock.
package clk_div_pkg;

  localparam int N_CH_DEF  = 3;
  localparam int DIV_W_DEF = 20;
  localparam int CH_IDX_W  = 4;

  // 25 MHz / 25 = 1 MHz, / 25000 = 1 kHz, / 500000 = 50 Hz
  localparam logic [DIV_W_DEF-1:0] DIV_1MHZ = 20'd25;
  localparam logic [DIV_W_DEF-1:0] DIV_1KHZ = 20'd25000;
  localparam logic [DIV_W_DEF-1:0] DIV_50HZ = 20'd500000;

  localparam logic [N_CH_DEF*DIV_W_DEF-1:0] RST_DIV_DEF = {DIV_50HZ, DIV_1KHZ, DIV_1MHZ};

  typedef enum logic [1:0] {
    DIV_KEEP,
    DIV_FROM_PEND,
    DIV_FROM_WR
  } div_src_e;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active/pending divisor registers and
// registered square-wave and end-of-period tick outputs.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int               DIV_W   = DIV_W_DEF,
  parameter logic [DIV_W-1:0] RST_DIV = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic             running;
  logic             wrap;
  logic [DIV_W-1:0] last_cnt;
  logic [DIV_W-1:0] half_div;
  div_src_e         div_src;

  always_comb begin
    running  = en && (div_q != '0);
    last_cnt = div_q - ONE;
    half_div = (div_q >> 1) + {{(DIV_W-1){1'b0}}, div_q[0]};
    wrap     = running && (cnt_q >= last_cnt);
  end

  // Outputs are derived from the count held during this cycle.
  always_comb begin
    clk_out_d = running && (cnt_q < half_div);
    tick_d    = running && (cnt_q == last_cnt);
  end

  always_comb begin
    cnt_d = '0;
    if (running && !sync && !wrap) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // A restarting counter (stopped or sync) takes a write directly; a running
  // one parks it in the pending register until the period boundary.
  always_comb begin
    div_src    = DIV_KEEP;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (!running || sync) begin
      if (wr) begin
        div_src = DIV_FROM_WR;
      end else if (pend_vld_q) begin
        div_src = DIV_FROM_PEND;
      end
      pend_vld_d = 1'b0;
    end else begin
      if (wrap) begin
        if (pend_vld_q) begin
          div_src = DIV_FROM_PEND;
        end
        pend_vld_d = 1'b0;
      end
      if (wr) begin
        pend_d     = wr_div;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (div_src)
      DIV_FROM_PEND: div_d = pend_q;
      DIV_FROM_WR:   div_d = wr_div;
      default:       div_d = div_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= RST_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/prog_clk_div.sv
// Programmable clock divider top: decodes divisor writes and fans sync/enable
// out to N_CH independent divider channels.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int                      N_CH    = N_CH_DEF,
  parameter int                      DIV_W   = DIV_W_DEF,
  parameter logic [N_CH*DIV_W-1:0]   RST_DIV = RST_DIV_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [CH_IDX_W-1:0] wr_ch,
  input  logic [DIV_W-1:0]    wr_div,
  input  logic [N_CH-1:0]     ch_en,
  input  logic                sync,
  output logic [N_CH-1:0]     clk_out,
  output logic [N_CH-1:0]     tick
);

  localparam logic [CH_IDX_W:0] N_CH_IDX = N_CH[CH_IDX_W:0];

  logic            wr_ok;
  logic [N_CH-1:0] wr_hit;

  // Writes addressed beyond the last channel are dropped here.
  always_comb begin
    wr_ok = wr_en && ({1'b0, wr_ch} < N_CH_IDX);
    for (int i = 0; i < N_CH; i++) begin
      wr_hit[i] = wr_ok && (wr_ch == CH_IDX_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clk_div_ch #(
      .DIV_W   (DIV_W),
      .RST_DIV (RST_DIV[g*DIV_W +: DIV_W])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (ch_en[g]),
      .sync    (sync),
      .wr      (wr_hit[g]),
      .wr_div  (wr_div),
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 Parameter N_CH, default 3, number of independent divider channels (1..16).
REQ-002 Parameter DIV_W, default 20, divisor and counter width in bits.
REQ-003 Parameter RST_DIV, default {20'd500000, 20'd25000, 20'd25}, N_CH*DIV_W reset divisor vector with channel 0 in the LSBs; gives 50 Hz / 1 kHz / 1 MHz from the 25 MHz board clock.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 wr_en  input  1  divisor write strobe, one cycle per write.
REQ-007 wr_ch  input  4  target channel index for the write.
REQ-008 wr_div  input  DIV_W  new divisor value.
REQ-009 ch_en  input  N_CH  per-channel run enable, level-sensitive.
REQ-010 sync  input  1  one-cycle pulse; restarts all channel counters in phase.
REQ-011 clk_out  output  N_CH  per-channel divided square wave, registered.
REQ-012 tick  output  N_CH  per-channel one-cycle pulse at end of period, registered.

Function
REQ-013 Each channel holds an active divisor D, a pending divisor P, a pending flag and a counter cnt (DIV_W bits).
REQ-014 Running channel (ch_en=1, D>=1): cnt counts 0,1,...,D-1,0, one step per clk.
REQ-015 clk_out(n+1) SHALL equal (cnt(n) < ceil(D/2)): high ceil(D/2) cycles, low floor(D/2) cycles per period.
REQ-016 tick(n+1) SHALL equal (cnt(n) == D-1); one cycle high per period; D=1 gives tick and clk_out continuously high.
REQ-017 D=0 or ch_en=0: cnt held at 0; clk_out and tick driven 0 from the next edge.
REQ-018 Write with wr_ch < N_CH, channel running with D>=1: P<=wr_div and pending set; D<=P at the edge where cnt wraps D-1->0. The current period always completes, so the output never glitches.
REQ-019 Write to a channel that is stopped (ch_en=0 or D=0): D<=wr_div immediately; cnt stays 0.
REQ-020 Write with wr_ch >= N_CH SHALL be ignored with no state change.
REQ-021 Second write before the wrap SHALL overwrite P; only the last value takes effect.
REQ-022 sync=1: every channel sets cnt<=0 and applies any pending P to D in the same edge.
REQ-023 sync and wr_en in the same cycle: the written value becomes D immediately for the addressed channel.
REQ-024 ch_en rising: the channel starts at cnt=0; the first clk_out high appears one cycle later.
REQ-025 ch_en falling mid-period: the counter stops at once; a pending P is applied to D.
REQ-026 A divisor write at the wrap edge: the old P (if any) loads; the new value becomes pending.

Reset
REQ-027 rst_n=0 SHALL immediately force clk_out=0, tick=0, cnt=0, D=RST_DIV slice, P=0 and pending=0 on all channels.
REQ-028 Reset mid-period SHALL discard all pending writes.
REQ-029 After reset release, counting begins on the first rising clk edge with ch_en=1.

Structure
REQ-030 Package clk_div_pkg SHALL hold the N_CH and DIV_W defaults, the default RST_DIV constants and the channel-index width.
REQ-031 Sub-module clk_div_ch (one channel: counter, D/P registers, output flops) SHALL be instantiated N_CH times via generate.
REQ-032 The top level SHALL contain only write decode, fan-out of sync/ch_en and output concatenation.

Verification
REQ-033 Reset, ch_en=3'b111, defaults -> ch0 tick every 25 cycles, clk_out 13 high / 12 low; ch1 tick every 25000; ch2 every 500000.
REQ-034 ch0 D=4, write 6 at cnt=1 -> current period ends after 4 cycles, then periods of 6 (3 high / 3 low).
REQ-035 Write D=0 to ch1 -> clk_out[1] and tick[1] are 0 from the next edge; write 1 -> tick[1] and clk_out[1] are constant 1.
REQ-036 Channels with D=5 and D=7 free-running, pulse sync -> both cnt=0 next edge; both tick together 35 cycles later.
REQ-037 Write with wr_ch=3 (N_CH=3) -> no output change; rst_n low mid-period -> outputs 0 asynchronously, defaults restored.
REQ-038 sync+wr_en to ch0 with 8 in the same cycle -> ch0 period 8 starting immediately, aligned with the other channels.
